// File: rtl/prog_sequencer.sv
// prog_sequencer: program-control and fetch sequencer for the 9-bit-ISA core.
// It selects the program entry point, runs the Start/Ack handshake, handles
// conditional relative/absolute branches and halt, and counts executed cycles.
//
// Optional feature macro: PROG_SEQ_BOUNDS_EN
//   When defined, every next-PC value produced in RUN is checked against the
//   window [entry, entry+PGM_STRIDE-1] of the running program. An out-of-window
//   value ends the run with Ack=1, Error=1, and ProgCtr keeps the last valid
//   address. When undefined, PC arithmetic wraps freely modulo 2**PC_W.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for Start
// LOAD  | Start held high; ProgCtr holds the selected entry point
// RUN   | fetching/executing; Running=1, CycleCt counting
// DONE  | run finished (halt, invalid PgmSel or bounds error); Ack held

module prog_sequencer #(
  parameter int PC_W       = 10,
  parameter int NUM_PGM    = 3,
  parameter int PGM_STRIDE = 256,
  parameter int OFF_W      = 8,
  parameter int CYC_W      = 16,
  parameter int PSEL_W     = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PSEL_W-1:0] PgmSel,
  input  logic              Halt,
  input  logic              JmpEq,
  input  logic              JmpNe,
  input  logic              AbsEn,
  input  logic              Zero,
  input  logic [PC_W-1:0]   Target,
  input  logic [OFF_W-1:0]  Offset,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Ack,
  output logic              Error,
  output logic [CYC_W-1:0]  CycleCt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PC_W-1:0]  pc_nx;
  logic [CYC_W-1:0] cyc_nx;
  logic             ack_nx;
  logic             err_nx;

  // Program selection: validity and truncated entry address.
  logic             pgm_valid;
  logic [PC_W-1:0]  entry_addr;

  assign pgm_valid  = int'(PgmSel) < NUM_PGM;
  assign entry_addr = PC_W'(int'(PgmSel) * PGM_STRIDE);

  // Candidate next PC in RUN; all arithmetic is modulo 2**PC_W.
  logic             taken;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  pc_seq;
  logic [PC_W-1:0]  pc_rel;
  logic [PC_W-1:0]  pc_cand;
  logic [CYC_W-1:0] cyc_inc;

  assign taken   = (JmpEq & Zero) | (JmpNe & ~Zero);
  assign off_ext = PC_W'($signed(Offset));
  assign pc_seq  = ProgCtr + PC_W'(1);
  assign pc_rel  = ProgCtr + off_ext;
  assign pc_cand = taken ? (AbsEn ? Target : pc_rel) : pc_seq;

  // Saturating cycle counter increment.
  assign cyc_inc = (CycleCt == {CYC_W{1'b1}}) ? CycleCt : CycleCt + CYC_W'(1);

`ifdef PROG_SEQ_BOUNDS_EN
  // Entry address of the program currently loaded/running, kept for the
  // window check. The upper bound is one bit wider so a window reaching the
  // top of the address space does not wrap.
  logic [PC_W-1:0] entry_q;
  logic [PC_W-1:0] entry_nx;
  logic [PC_W:0]   win_hi;
  logic            oob;

  assign win_hi = {1'b0, entry_q} + (PC_W+1)'(PGM_STRIDE - 1);
  assign oob    = (pc_cand < entry_q) || ({1'b0, pc_cand} > win_hi);
`endif

  // Next-state and next-output logic; Start takes priority in every state.
  always_comb begin
    state_nx = state;
    pc_nx    = ProgCtr;
    cyc_nx   = CycleCt;
    ack_nx   = Ack;
    err_nx   = Error;
`ifdef PROG_SEQ_BOUNDS_EN
    entry_nx = entry_q;
`endif
    if (Start) begin
      if (pgm_valid) begin
        state_nx = LOAD;
        pc_nx    = entry_addr;
        cyc_nx   = '0;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
`ifdef PROG_SEQ_BOUNDS_EN
        entry_nx = entry_addr;
`endif
      end else begin
        state_nx = DONE;
        ack_nx   = 1'b1;
        err_nx   = 1'b1;
      end
    end else begin
      case (state)
        LOAD: begin
          state_nx = RUN;
        end
        RUN: begin
          cyc_nx = cyc_inc;
          if (Halt) begin
            state_nx = DONE;
            ack_nx   = 1'b1;
          end
`ifdef PROG_SEQ_BOUNDS_EN
          else if (oob) begin
            state_nx = DONE;
            ack_nx   = 1'b1;
            err_nx   = 1'b1;
          end
`endif
          else begin
            pc_nx = pc_cand;
          end
        end
        default: begin
          state_nx = state;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered datapath outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ProgCtr <= '0;
      CycleCt <= '0;
      Ack     <= 1'b0;
      Error   <= 1'b0;
    end else begin
      ProgCtr <= pc_nx;
      CycleCt <= cyc_nx;
      Ack     <= ack_nx;
      Error   <= err_nx;
    end
  end

`ifdef PROG_SEQ_BOUNDS_EN
  // Entry address of the loaded program for the window check.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_nx;
    end
  end
`endif

  assign Running = (state == RUN);

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios with literal
// expectations followed by randomized stimulus, all compared every cycle
// against a behavioural model of the sequencer.
module tb_prog_sequencer;

  localparam int PC_W       = 10;
  localparam int NUM_PGM    = 3;
  localparam int PGM_STRIDE = 256;
  localparam int OFF_W      = 8;
  localparam int CYC_W      = 4;
  localparam int PSEL_W     = 2;
  localparam int DEPTH      = 1 << PC_W;
  localparam int CYC_MAX    = (1 << CYC_W) - 1;
  localparam bit BOUNDS     =
`ifdef PROG_SEQ_BOUNDS_EN
    1'b1;
`else
    1'b0;
`endif

  logic              Clk;
  logic              Reset;
  logic              Start;
  logic [PSEL_W-1:0] PgmSel;
  logic              Halt;
  logic              JmpEq;
  logic              JmpNe;
  logic              AbsEn;
  logic              Zero;
  logic [PC_W-1:0]   Target;
  logic [OFF_W-1:0]  Offset;
  logic [PC_W-1:0]   ProgCtr;
  logic              Running;
  logic              Ack;
  logic              Error;
  logic [CYC_W-1:0]  CycleCt;

  int n_checks = 0;
  int n_fail   = 0;

  prog_sequencer #(
    .PC_W(PC_W), .NUM_PGM(NUM_PGM), .PGM_STRIDE(PGM_STRIDE),
    .OFF_W(OFF_W), .CYC_W(CYC_W), .PSEL_W(PSEL_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .PgmSel(PgmSel), .Halt(Halt),
    .JmpEq(JmpEq), .JmpNe(JmpNe), .AbsEn(AbsEn), .Zero(Zero),
    .Target(Target), .Offset(Offset), .ProgCtr(ProgCtr), .Running(Running),
    .Ack(Ack), .Error(Error), .CycleCt(CycleCt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase codes are private to the bench: 0 idle, 1 loading, 2 running, 3 done.
  int m_phase, m_pc, m_cyc, m_entry, m_nxt;
  bit m_ack, m_err, m_valid, m_taken;

  initial begin
    m_valid = 1'b0;
    m_phase = 0; m_pc = 0; m_cyc = 0; m_entry = 0;
    m_ack = 1'b0; m_err = 1'b0;
  end

  always @(posedge Clk) begin
    if (Reset) begin
      m_phase = 0; m_pc = 0; m_cyc = 0; m_entry = 0;
      m_ack = 1'b0; m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (Start) begin
        if (int'(PgmSel) < NUM_PGM) begin
          m_phase = 1;
          m_entry = (int'(PgmSel) * PGM_STRIDE) % DEPTH;
          m_pc = m_entry; m_cyc = 0; m_ack = 1'b0; m_err = 1'b0;
        end else begin
          m_phase = 3; m_ack = 1'b1; m_err = 1'b1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2) begin
        if (m_cyc < CYC_MAX) m_cyc = m_cyc + 1;
        m_taken = (JmpEq && Zero) || (JmpNe && !Zero);
        if (!m_taken)   m_nxt = m_pc + 1;
        else if (AbsEn) m_nxt = int'(Target);
        else            m_nxt = m_pc + int'($signed(Offset));
        m_nxt = ((m_nxt % DEPTH) + DEPTH) % DEPTH;
        if (Halt) begin
          m_phase = 3; m_ack = 1'b1;
        end else if (BOUNDS && (m_nxt < m_entry || m_nxt > m_entry + PGM_STRIDE - 1)) begin
          m_phase = 3; m_ack = 1'b1; m_err = 1'b1;
        end else begin
          m_pc = m_nxt;
        end
      end
    end
  end

  // Compare DUT to the model on every falling edge once reset has been seen.
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("m_ProgCtr", int'(ProgCtr), m_pc);
      chk("m_CycleCt", int'(CycleCt), m_cyc);
      chk("m_Running", int'(Running), int'(m_phase == 2));
      chk("m_Ack",     int'(Ack),     int'(m_ack));
      chk("m_Error",   int'(Error),   int'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic ctl(input bit jeq, input bit jne, input bit abs_en, input bit z,
                     input int tgt, input int off);
    JmpEq = jeq; JmpNe = jne; AbsEn = abs_en; Zero = z;
    Target = PC_W'(tgt); Offset = OFF_W'(off);
  endtask

  task automatic load_pgm(input int p);
    Start = 1'b1; PgmSel = PSEL_W'(p);
    step();
    Start = 1'b0;
    step();
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; PgmSel = '0; Halt = 1'b0;
    ctl(0, 0, 0, 0, 0, 0);
    step(); step();
    Reset = 1'b0;
    chk("rst_pc", int'(ProgCtr), 0);
    chk("rst_ack", int'(Ack), 0);
    chk("rst_err", int'(Error), 0);
    chk("rst_cyc", int'(CycleCt), 0);
    chk("rst_run", int'(Running), 0);

    // Entry selection and sequential fetch.
    Start = 1'b1; PgmSel = 2'd1;
    step();
    chk("load_pc", int'(ProgCtr), 256);
    chk("load_run", int'(Running), 0);
    step();
    Start = 1'b0;
    step();
    chk("run0_pc", int'(ProgCtr), 256);
    chk("run0_running", int'(Running), 1);
    step(); chk("run1_pc", int'(ProgCtr), 257);
    step(); chk("run2_pc", int'(ProgCtr), 258);

    // Branches.
    ctl(1, 1, 1, 0, 300, 0); step();
    chk("jabs300", int'(ProgCtr), 300);
    ctl(0, 1, 0, 0, 0, 8'hFC); step();
    chk("jne_taken", int'(ProgCtr), 296);
    ctl(1, 1, 1, 0, 300, 0); step();
    ctl(0, 1, 0, 1, 0, 8'hFC); step();
    chk("jne_not_taken", int'(ProgCtr), 301);
    ctl(1, 0, 1, 1, 5, 0); step();
    chk("jeq_abs5", int'(ProgCtr), BOUNDS ? 301 : 5);
    chk("jeq_abs5_err", int'(Error), BOUNDS ? 1 : 0);
    ctl(0, 0, 0, 0, 0, 0);

    // Halt after 5 RUN cycles, Ack held, cleared by a new Start.
    load_pgm(0);
    chk("pgm0_cyc", int'(CycleCt), 0);
    repeat (4) step();
    Halt = 1'b1; step(); Halt = 1'b0;
    chk("halt_ack", int'(Ack), 1);
    chk("halt_running", int'(Running), 0);
    chk("halt_cyc", int'(CycleCt), 5);
    chk("halt_pc", int'(ProgCtr), 4);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ack_hold", int'(Ack), 1);
    end
    Start = 1'b1; PgmSel = 2'd2; step();
    chk("restart_ack", int'(Ack), 0);
    chk("restart_pc", int'(ProgCtr), 512);

    // Invalid program, then abort mid-run.
    PgmSel = 2'd3; step();
    chk("bad_ack", int'(Ack), 1);
    chk("bad_err", int'(Error), 1);
    chk("bad_pc", int'(ProgCtr), 512);
    PgmSel = 2'd2; step();
    chk("reload_err", int'(Error), 0);
    Start = 1'b0; step();
    repeat (3) step();
    Start = 1'b1; step();
    chk("abort_ack", int'(Ack), 0);
    chk("abort_cyc", int'(CycleCt), 0);
    chk("abort_running", int'(Running), 0);

    // Saturation and top-of-space wrap.
    Start = 1'b0; step();
    repeat (20) step();
    chk("cyc_sat", int'(CycleCt), 15);
    ctl(1, 1, 1, 0, 1023, 0); step();
    ctl(0, 0, 0, 0, 0, 0); step();
    chk("wrap_pc", int'(ProgCtr), BOUNDS ? 532 : 0);

    // Program-0 window edge, then halt priority at the same spot.
    load_pgm(0);
    ctl(1, 1, 1, 0, 255, 0); step();
    ctl(0, 0, 0, 0, 0, 0); step();
    chk("edge_pc", int'(ProgCtr), BOUNDS ? 255 : 256);
    chk("edge_ack", int'(Ack), BOUNDS ? 1 : 0);
    chk("edge_err", int'(Error), BOUNDS ? 1 : 0);
    load_pgm(0);
    ctl(1, 1, 1, 0, 255, 0); step();
    ctl(0, 0, 0, 0, 0, 0);
    Halt = 1'b1; step(); Halt = 1'b0;
    chk("edge_halt_ack", int'(Ack), 1);
    chk("edge_halt_err", int'(Error), 0);
    chk("edge_halt_pc", int'(ProgCtr), 255);

    // Reset mid-run.
    load_pgm(2);
    repeat (3) step();
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("midrst_pc", int'(ProgCtr), 0);
    chk("midrst_cyc", int'(CycleCt), 0);
    chk("midrst_running", int'(Running), 0);
    chk("midrst_ack", int'(Ack), 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      Reset  = ($urandom_range(0, 299) == 0);
      Start  = ($urandom_range(0, 19) == 0);
      PgmSel = PSEL_W'($urandom_range(0, 3));
      Halt   = ($urandom_range(0, 39) == 0);
      JmpEq  = ($urandom_range(0, 3) == 0);
      JmpNe  = ($urandom_range(0, 3) == 0);
      AbsEn  = $urandom_range(0, 1) == 1;
      Zero   = $urandom_range(0, 1) == 1;
      Target = PC_W'($urandom_range(0, DEPTH - 1));
      Offset = ($urandom_range(0, 7) == 0) ? OFF_W'($urandom_range(0, 255))
                                           : OFF_W'($urandom_range(0, 32) - 16);
      step();
    end
    Reset = 1'b0; Start = 1'b0; Halt = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Parametrised program-control and fetch-sequencing unit for the 9-bit-ISA processor. It replaces the single-program counter and replaces top-level cycle counting with these functions:
- multi-program entry selection
- the Start/Ack run handshake
- conditional relative and absolute branching
- halt detection and a saturating cycle counter

It sits between the control decoder/ALU (branch and halt controls, Zero flag) and the instruction ROM (ProgCtr).

Parameters:
PC_W, 10, program-counter width; instruction ROM depth is 2**PC_W.
NUM_PGM, 3, number of selectable programs (1..2**PSEL_W).
PGM_STRIDE, 256, address spacing of program entry points; entry address of program k = k*PGM_STRIDE.
OFF_W, 8, width of the signed relative branch offset.
CYC_W, 16, cycle-counter width.
PSEL_W, 2, width of PgmSel.

Ports:
Clk  in  1  clock; all state updates on posedge.
Reset  in  1  synchronous, active-high reset.
Start  in  1  run request: held high to load an entry point, falling edge begins execution.
PgmSel  in  PSEL_W  program index, sampled while Start=1.
Halt  in  1  decoder: current instruction is halt/done.
JmpEq  in  1  decoder: branch if Zero=1.
JmpNe  in  1  decoder: branch if Zero=0.
AbsEn  in  1  decoder: 1 = absolute branch to Target, 0 = relative by Offset.
Zero  in  1  ALU zero flag.
Target  in  PC_W  absolute branch target (register/LUT value).
Offset  in  OFF_W  two's-complement relative offset.
ProgCtr  out  PC_W  instruction address to instruction ROM.
Running  out  1  high while in RUN.
Ack  out  1  program-done flag.
Error  out  1  run ended abnormally.
CycleCt  out  CYC_W  instructions executed in current/last run.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, with ports named Clk and Reset.
- Reset values: state=IDLE, ProgCtr=0, Running=0, Ack=0, Error=0, CycleCt=0. Reset overrides all other inputs in any state, including mid-run.
- States are IDLE, LOAD, RUN and DONE. All outputs are registered; Running decodes state==RUN.
- IDLE:
  - Start=1 with PgmSel<NUM_PGM: go to LOAD; ProgCtr <= PgmSel*PGM_STRIDE (truncated to PC_W); CycleCt<=0; Error<=0.
  - Start=1 with PgmSel>=NUM_PGM: go to DONE; Ack<=1, Error<=1; ProgCtr unchanged.
- LOAD:
  - While Start=1, re-evaluate PgmSel each cycle using the same IDLE rules; the last value sampled wins.
  - Start=0: go to RUN on the next edge. ProgCtr holds the entry address, and the first RUN cycle fetches it.
- RUN, evaluated each cycle in this priority order:
  1. Start=1 aborts the run: go to LOAD and apply the IDLE/LOAD rules. Ack stays 0.
  2. Halt=1: go to DONE; Ack<=1; ProgCtr holds; CycleCt counts this cycle.
  3. taken = (JmpEq&Zero)|(JmpNe&~Zero), so JmpEq&JmpNe together is an unconditional jump.
     - If taken and AbsEn=1: ProgCtr<=Target.
     - If taken and AbsEn=0: ProgCtr<=ProgCtr+sign_extend(Offset).
  4. Otherwise ProgCtr<=ProgCtr+1.
  - All PC arithmetic is modulo 2**PC_W, so wrap-around past the top address is silent unless PROG_SEQ_BOUNDS_EN is defined.
  - CycleCt increments by 1 on every RUN cycle and saturates at 2**CYC_W-1.
- DONE:
  - Ack=1 and is held; ProgCtr, CycleCt and Error hold.
  - Start=1: go to LOAD and apply the IDLE/LOAD rules; Ack<=0 on that same edge.
- Latency: Start falling edge to first fetch of the entry address is 1 cycle. Halt to Ack=1 is 1 cycle.
- Branch controls are ignored outside RUN.

Optional Feature:
PROG_SEQ_BOUNDS_EN.
- Defined: in RUN, any next-PC value outside the window [entry, entry+PGM_STRIDE-1] is out of bounds. This covers sequential overflow and taken branches.
  - An out-of-bounds next-PC forces DONE with Ack<=1 and Error<=1, and ProgCtr holds the last valid address.
  - Halt in the same cycle takes priority, giving Error=0.
- Not defined: no window check; PC wraps freely and Error is set only by an invalid PgmSel.

Test Plan:
1. Reset, then Start=1 with PgmSel=1 for 2 cycles, then Start=0 -> ProgCtr=256 in LOAD; ProgCtr 256,257,258 on successive RUN cycles; Running=1.
2. RUN at PC=300 with JmpNe=1, Zero=0, AbsEn=0, Offset=8'hFC -> ProgCtr=296. Same with Zero=1 -> ProgCtr=301. JmpEq=1, Zero=1, AbsEn=1, Target=10'h05 -> ProgCtr=5.
3. Halt=1 after 5 RUN cycles -> next cycle Ack=1, Running=0, CycleCt=5; Ack stays 1 for 10 idle cycles; a new Start clears Ack on the first edge.
4. Start=1 with PgmSel=3 (NUM_PGM=3) -> DONE with Ack=1, Error=1. Start=1 mid-RUN -> returns to LOAD with Ack=0 and CycleCt=0.
5. CYC_W=4, run 20 cycles -> CycleCt saturates at 15. PC_W=10, PC=1023 with no branch -> next PC=0 when PROG_SEQ_BOUNDS_EN is undefined.
6. PROG_SEQ_BOUNDS_EN defined, program 0, PC=255 sequential -> Ack=1, Error=1, ProgCtr=255. Same cycle with Halt=1 -> Error=0. Assert Reset mid-RUN -> all outputs return to 0.
